// File: rtl/ro_meas_pkg.sv
// Shared types and helpers for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        STORE   = 2'd3
    } state_t;

    localparam int SYNC_STAGES = 2;

    // Lowest set bit strictly above cur (cur = -1 searches from bit 0) among the low n bits;
    // if none and wrap is set, the lowest set bit overall. Returns -1 when nothing qualifies.
    function automatic int next_set_bit(input logic [31:0] mask, input int cur,
                                        input int n, input logic wrap);
        int r;
        r = -1;
        for (int i = 31; i >= 0; i--) begin
            if (i > cur && i < n && mask[i]) r = i;
        end
        if (r < 0 && wrap) begin
            for (int i = 31; i >= 0; i--) begin
                if (i < n && mask[i]) r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ro_meas_sequencer_counter.sv
// Synchronizes the muxed ring output, detects rising edges and counts them with saturation.
module ro_edge_counter
    import ro_meas_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             clr,
    input  logic             en,
    input  logic             prime,
    output logic [CNT_W-1:0] count_next,
    output logic             ovf_next
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   rise;
    logic [CNT_W-1:0]       count;
    logic                   ovf;

    // History only tracks while priming or counting, so the first measured cycle compares
    // against a settled sample rather than a stale one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            hist  <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], ro_in};
            hist  <= (prime || en) ? sync[SYNC_STAGES-1] : 1'b0;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

    assign rise = en && sync[SYNC_STAGES-1] && !hist;

    // Next-state view includes this cycle's edge so the caller can capture the final count
    // on the same edge that closes the window.
    always_comb begin
        count_next = count;
        ovf_next   = ovf;
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (rise) begin
            if (&count) ovf_next = 1'b1;
            else        count_next = count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ro_meas_sequencer.sv
// Steps through the enabled ring oscillators: settle, count edges over a window, report.
module ro_meas_sequencer
    import ro_meas_pkg::*;
#(
    parameter int N_OSC      = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cont,
    input  logic [N_OSC-1:0]         osc_mask,
    input  logic [WIN_W-1:0]         window,
    input  logic                     ro_in,
    output logic [N_OSC-1:0]         ro_en,
    output logic [$clog2(N_OSC)-1:0] ro_sel,
    output logic                     busy,
    output logic [CNT_W-1:0]         result,
    output logic [$clog2(N_OSC)-1:0] result_id,
    output logic                     result_valid,
    output logic                     overflow,
    output logic                     done
);

    localparam int IDX_W = $clog2(N_OSC);
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > ST_W) ? WIN_W : ST_W;

    state_t           state, state_nxt;
    logic [N_OSC-1:0] mask_q;
    logic [WIN_W-1:0] win_q;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [TMR_W-1:0] tmr, tmr_lim;
    logic             tmr_last;
    logic             done_nxt;
    logic             capture;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    int               seek;

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .ro_in      (ro_in),
        .clr        (state == SETTLE),
        .en         (state == MEASURE),
        .prime      (state == SETTLE),
        .count_next (cnt_next),
        .ovf_next   (ovf_next)
    );

    // tmr runs 1..limit inside each state and restarts on every transition.
    assign tmr_lim  = (state == SETTLE) ? TMR_W'(SETTLE_CYC) : TMR_W'(win_q);
    assign tmr_last = (tmr == tmr_lim);
    assign capture  = (state == MEASURE) && tmr_last;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        seek      = -1;
        case (state)
            IDLE: begin
                if (start) begin
                    seek = next_set_bit(32'(osc_mask), -1, N_OSC, 1'b0);
                    if (seek >= 0) begin
                        state_nxt = SETTLE;
                        idx_nxt   = IDX_W'(seek);
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            SETTLE:  if (tmr_last) state_nxt = MEASURE;
            MEASURE: if (tmr_last) state_nxt = STORE;
            STORE: begin
                seek = next_set_bit(32'(mask_q), int'(idx), N_OSC, cont);
                if (seek >= 0) begin
                    state_nxt = SETTLE;
                    idx_nxt   = IDX_W'(seek);
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            tmr          <= TMR_W'(1);
            mask_q       <= '0;
            win_q        <= '0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            result_id    <= '0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            tmr          <= (state_nxt != state) ? TMR_W'(1) : tmr + TMR_W'(1);
            done         <= done_nxt;
            result_valid <= capture;
            if (state == IDLE && start) begin
                mask_q <= osc_mask;
                win_q  <= (window == '0) ? WIN_W'(1) : window;
            end
            if (capture) begin
                result    <= cnt_next;
                overflow  <= ovf_next;
                result_id <= idx;
            end
        end
    end

    // Enable dropped in STORE gives the break-before-make gap between oscillators.
    always_comb begin
        ro_en = '0;
        if (state == SETTLE || state == MEASURE) ro_en[idx] = 1'b1;
    end

    assign ro_sel = idx;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Directed and randomized sweeps of ro_meas_sequencer against an edge-count reference model.
module tb_ro_meas_sequencer;

    localparam int N_OSC = 4, CNT_W = 16, WIN_W = 16, SETTLE_CYC = 16, SMALL_W = 4;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cont = 1'b0, ro_in = 1'b0;
    logic [N_OSC-1:0] osc_mask = '0;
    logic [WIN_W-1:0] window = '0;
    logic [N_OSC-1:0] ro_en, ro_en_s;
    logic [1:0] ro_sel, ro_sel_s, result_id, result_id_s;
    logic busy, busy_s, result_valid, result_valid_s, overflow, overflow_s, done, done_s;
    logic [CNT_W-1:0] result;
    logic [SMALL_W-1:0] result_s;

    ro_meas_sequencer #(.N_OSC(N_OSC), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .osc_mask(osc_mask), .window(window),
        .ro_in(ro_in), .ro_en(ro_en), .ro_sel(ro_sel), .busy(busy), .result(result),
        .result_id(result_id), .result_valid(result_valid), .overflow(overflow), .done(done));

    ro_meas_sequencer #(.N_OSC(N_OSC), .CNT_W(SMALL_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC)) dut_s (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .osc_mask(osc_mask), .window(window),
        .ro_in(ro_in), .ro_en(ro_en_s), .ro_sel(ro_sel_s), .busy(busy_s), .result(result_s),
        .result_id(result_id_s), .result_valid(result_valid_s), .overflow(overflow_s), .done(done_s));

    always #5 clk = ~clk;

    // Periodic ring stand-in: high for ro_h of every ro_p cycles, changing away from clk edges.
    int ro_p = 4, ro_h = 2, ro_ph = 0;
    always @(posedge clk) begin
        #2;
        ro_ph = (ro_ph + 1 >= ro_p) ? 0 : ro_ph + 1;
        ro_in = (ro_ph < ro_h);
    end

    typedef struct {int id; int lo; int hi; int ovf;} exp_t;
    exp_t q[$];

    int n_cmp = 0, n_err = 0, cyc = 0, res_seen = 0, done_cnt = 0;
    int last_valid_cyc = 0, last_done_cyc = 0, small_seen = 0;
    bit chk_small = 0;
    logic [N_OSC-1:0] prev_en = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ro_en != '0) check("en_matches_sel", 32'(ro_en), 32'(4'b0001 << ro_sel));
        if (!busy) check("idle_en_zero", 32'(ro_en), 0);
        if (prev_en != '0 && ro_en != '0) check("break_before_make", 32'(ro_en), 32'(prev_en));
        prev_en = ro_en;
        if (result_valid) begin
            res_seen++;
            last_valid_cyc = cyc;
            check("store_en_zero", 32'(ro_en), 0);
            n_cmp++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_valid: observed result_id=%0d result=%0d expected no result", result_id, result);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("result_id", 32'(result_id), e.id);
                check("overflow", 32'(overflow), e.ovf);
                if (e.lo == e.hi) check("result", 32'(result), e.lo);
                else begin
                    n_cmp++;
                    assert (int'(result) >= e.lo && int'(result) <= e.hi) else begin
                        n_err++;
                        $error("FAIL result_range: observed %0d expected %0d..%0d", result, e.lo, e.hi);
                    end
                end
            end
        end
        if (chk_small && result_valid_s) begin
            small_seen++;
            check("small_result", 32'(result_s), 15);
            check("small_overflow", 32'(overflow_s), 1);
            check("small_id", 32'(result_id_s), 0);
            check("small_busy", 32'(busy_s), 1);
            check("small_done", 32'(done_s), 0);
            check("small_en", 32'(ro_en_s), 32'(ro_sel_s) & 0);
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    endtask

    // Reference: periodic input gives exactly w/p synchronized rising edges in any w-cycle
    // window when p divides w; a single-cycle window sees at most one.
    task automatic push_sweep(input logic [N_OSC-1:0] m, input int w, input int p, input int cw);
        exp_t e;
        int c, mx;
        mx = (1 << cw) - 1;
        for (int i = 0; i < N_OSC; i++) begin
            if (m[i]) begin
                e.id = i;
                if (w == 0) begin
                    e.lo = 0; e.hi = 1; e.ovf = 0;
                end else begin
                    c = w / p;
                    e.lo = (c > mx) ? mx : c;
                    e.hi = e.lo;
                    e.ovf = (c > mx) ? 1 : 0;
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        n_cmp++;
        assert (done_cnt != d0) else begin
            n_err++;
            $error("FAIL done_timeout: observed no done in %0d cycles expected a done pulse", n);
        end
    endtask

    task automatic wait_res(input int target, input int budget);
        int n = 0;
        while (res_seen < target && n < budget) begin
            step();
            n++;
        end
        check("result_count_reached", res_seen, target);
    endtask

    task automatic sweep(input logic [N_OSC-1:0] m, input int w, input int p, input int h);
        int r0;
        ro_p = p; ro_h = h;
        osc_mask = m; window = WIN_W'(w);
        push_sweep(m, w, p, CNT_W);
        r0 = res_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(N_OSC * (SETTLE_CYC + w + 4) + 20);
        check("sweep_pending", q.size(), 0);
        check("sweep_results", res_seen - r0, $countones(m));
        check("sweep_busy_end", 32'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0, r0, d0, p, h, w;
        logic [N_OSC-1:0] m;

        repeat (3) step();
        check("rst_ro_en", 32'(ro_en), 0);
        check("rst_ro_sel", 32'(ro_sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_result", 32'(result), 0);
        check("rst_result_id", 32'(result_id), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        step();

        // Single oscillator, latency and done timing; the narrow-counter instance saturates.
        ro_p = 4; ro_h = 2;
        osc_mask = 4'b0001; window = 16'd100;
        push_sweep(4'b0001, 100, 4, CNT_W);
        chk_small = 1;
        c0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_first_en", 32'(ro_en), 1);
        check("t1_busy", 32'(busy), 1);
        wait_done(400);
        chk_small = 0;
        check("t1_latency", last_valid_cyc - c0, SETTLE_CYC + 101);
        check("t1_done_gap", last_done_cyc - last_valid_cyc, 1);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_pending", q.size(), 0);
        check("t3_small_seen", small_seen, 1);

        // Two sparse oscillators; ro_sel holds the last index afterwards.
        sweep(4'b1010, 40, 8, 4);
        check("t2_sel_hold", 32'(ro_sel), 3);

        // Continuous sweeps, cont dropped while measuring id 2 of the second pass.
        ro_p = 4; ro_h = 2;
        osc_mask = 4'b0101; window = 16'd16; cont = 1'b1;
        push_sweep(4'b0101, 16, 4, CNT_W);
        push_sweep(4'b0101, 16, 4, CNT_W);
        r0 = res_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_res(r0 + 3, 300);
        repeat (SETTLE_CYC + 2) step();
        check("t4_measure_id2", 32'(ro_en), 4);
        cont = 1'b0;
        wait_done(200);
        check("t4_results", res_seen - r0, 4);
        check("t4_pending", q.size(), 0);

        // Start while busy must not disturb the sweep in progress.
        ro_p = 4; ro_h = 2;
        osc_mask = 4'b0001; window = 16'd100;
        push_sweep(4'b0001, 100, 4, CNT_W);
        r0 = res_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        osc_mask = 4'b1111; window = 16'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(400);
        check("t5_busy_start_results", res_seen - r0, 1);
        check("t5_busy_start_pending", q.size(), 0);

        // Reset mid-measure discards the measurement.
        osc_mask = 4'b0001; window = 16'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (SETTLE_CYC + 20) step();
        check("t5_in_measure", 32'(ro_en), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_en", 32'(ro_en), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_valid", 32'(result_valid), 0);
        check("t5_rst_done", 32'(done), 0);
        d0 = done_cnt;
        r0 = res_seen;
        repeat (200) step();
        check("t5_no_done", done_cnt, d0);
        check("t5_no_result", res_seen, r0);
        sweep(4'b0100, 24, 6, 3);

        // Empty mask: done only.
        osc_mask = 4'b0000;
        r0 = res_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_empty_done", 32'(done), 1);
        check("t6_empty_busy", 32'(busy), 0);
        step();
        check("t6_empty_done_clear", 32'(done), 0);
        repeat (5) step();
        check("t6_empty_results", res_seen, r0);

        // Zero window behaves as a single-cycle window.
        sweep(4'b0001, 0, 4, 2);

        // Randomized sweeps.
        for (int k = 0; k < 6; k++) begin
            m = N_OSC'($urandom_range(1, 15));
            p = int'($urandom_range(4, 9));
            h = int'($urandom_range(2, p - 2));
            w = p * int'($urandom_range(1, 12));
            repeat (3) step();
            sweep(m, w, p, h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
